// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter for an 800x600 raster with 4x4 pixel replication.
// Display fetches always take the RAM. Host writes use the remaining cycles.
module vga_fb_arbiter #(
    parameter int unsigned FB_W      = 200,
    parameter int unsigned FB_H      = 150,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned TEAR_FREE = 0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              active_zone,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic [10:0]       x_pos,
    input  logic [10:0]       y_pos,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        rgb_out,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              de_out,
    output logic              frame_start
);

    typedef enum logic {ST_ACTIVE, ST_VBLANK} state_t;

    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_hs;
    logic [1:0]        r_vs;
    logic [1:0]        r_de;
    logic              r_fetch;
    logic [7:0]        r_rgb;
    logic              r_drop;
    logic              r_frame_start;
    logic              w_frame_start_set;

    logic [10:0]       w_x;
    logic [10:0]       w_y;
    logic [8:0]        w_x_fb;
    logic [8:0]        w_y_fb;
    logic              w_disp_slot;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_in_range;
    logic              w_grant_ok;
    logic              w_accept;
    logic              w_vs_fall;

    // Raster coordinates float while blanking; mask them so nothing undefined leaks.
    assign w_x         = active_zone ? x_pos : '0;
    assign w_y         = active_zone ? y_pos : '0;
    assign w_x_fb      = w_x[10:2];
    assign w_y_fb      = w_y[10:2];
    assign w_disp_slot = active_zone & (w_x[1:0] == 2'b00);

    generate
        if (FB_W == 200) begin : g_shift_mul
            assign w_disp_addr = ADDR_W'({w_y_fb, 7'b0}) + ADDR_W'({w_y_fb, 6'b0})
                               + ADDR_W'({w_y_fb, 3'b0}) + ADDR_W'(w_x_fb);
        end else begin : g_generic_mul
            assign w_disp_addr = ADDR_W'(w_y_fb * FB_W + w_x_fb);
        end
    endgenerate

    assign w_in_range = (wr_addr < FB_SIZE);
    assign w_grant_ok = (TEAR_FREE == 0) | (r_state == ST_VBLANK);
    assign wr_ready   = rst & ~w_disp_slot & w_grant_ok;
    assign w_accept   = wr_valid & wr_ready;
    assign w_vs_fall  = r_vs[0] & ~v_sync_in;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (w_disp_slot) begin
            mem_addr = w_disp_addr;
        end else if (w_accept && w_in_range) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_frame_start_set = 1'b0;
        case (r_state)
            ST_ACTIVE: if (w_vs_fall) w_state_next = ST_VBLANK;
            ST_VBLANK: begin
                if (active_zone) begin
                    w_state_next      = ST_ACTIVE;
                    w_frame_start_set = 1'b1;
                end
            end
            default: w_state_next = ST_VBLANK;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= ST_VBLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // r_vs[0] doubles as the previous v_sync sample for edge detection.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_hs          <= '1;
            r_vs          <= '1;
            r_de          <= '0;
            r_fetch       <= 1'b0;
            r_rgb         <= '0;
            r_drop        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hs          <= {r_hs[0], h_sync_in};
            r_vs          <= {r_vs[0], v_sync_in};
            r_de          <= {r_de[0], active_zone};
            r_fetch       <= w_disp_slot;
            r_drop        <= w_accept & ~w_in_range;
            r_frame_start <= w_frame_start_set;
            if (r_fetch) begin
                r_rgb <= mem_rdata;
            end
        end
    end

    assign rgb_out     = r_de[1] ? r_rgb : '0;
    assign h_sync_out  = r_hs[1];
    assign v_sync_out  = r_vs[1];
    assign de_out      = r_de[1];
    assign wr_drop     = r_drop;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench: two arbiters (normal and tear-free) sharing stimulus, each with its own RAM model.
module tb_vga_fb_arbiter;

    logic        clock = 1'b0;
    logic        rst;
    logic        active_zone;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;

    logic        wr_ready0, wr_drop0, mem_we0, hso0, vso0, de0, fs0;
    logic [14:0] mem_addr0;
    logic [7:0]  mem_wdata0, mem_rdata0, rgb0;
    logic        wr_ready1, wr_drop1, mem_we1, hso1, vso1, de1, fs1;
    logic [14:0] mem_addr1;
    logic [7:0]  mem_wdata1, mem_rdata1, rgb1;

    logic [7:0]  ram0 [0:32767];
    logic [7:0]  ram1 [0:32767];
    logic        pl_en;
    logic [14:0] pl_addr;
    logic [7:0]  pl_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_rgb_a [0:11];
    logic [7:0] exp_rgb_b [0:7];
    logic [7:0] rnd_data  [0:31];

    always #5 clock = ~clock;

    vga_fb_arbiter #(.FB_W(200), .FB_H(150), .ADDR_W(15), .TEAR_FREE(0)) dut0 (
        .clock(clock), .rst(rst), .active_zone(active_zone),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .x_pos(x_pos), .y_pos(y_pos),
        .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop0), .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .rgb_out(rgb0), .h_sync_out(hso0), .v_sync_out(vso0),
        .de_out(de0), .frame_start(fs0)
    );

    vga_fb_arbiter #(.FB_W(200), .FB_H(150), .ADDR_W(15), .TEAR_FREE(1)) dut1 (
        .clock(clock), .rst(rst), .active_zone(active_zone),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .x_pos(x_pos), .y_pos(y_pos),
        .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop1), .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .rgb_out(rgb1), .h_sync_out(hso1), .v_sync_out(vso1),
        .de_out(de1), .frame_start(fs1)
    );

    always @(posedge clock) begin
        if (pl_en) begin
            ram0[pl_addr] <= pl_data;
            ram1[pl_addr] <= pl_data;
        end else begin
            if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
            if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
        end
        mem_rdata0 <= ram0[mem_addr0];
        mem_rdata1 <= ram1[mem_addr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pix(input logic az, input int x, input int y);
        active_zone = az;
        if (az) begin
            x_pos = 11'(x);
            y_pos = 11'(y);
        end else begin
            x_pos = 'z;
            y_pos = 'z;
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        exp_rgb_a = '{8'h00, 8'h00, 8'hE0, 8'hE0, 8'hE0, 8'hE0,
                      8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h00, 8'h00};
        exp_rgb_b = '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00};

        rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        pix(1'b0, 0, 0); h_sync_in = 1'b1; v_sync_in = 1'b1;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        tick();

        // Reset state
        wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 8'h11;
        settle();
        chk("rst_rgb", rgb0, 8'h00);
        chk("rst_de", de0, 1'b0);
        chk("rst_fs", fs0, 1'b0);
        chk("rst_drop", wr_drop0, 1'b0);
        chk("rst_hs", hso0, 1'b1);
        chk("rst_vs", vso0, 1'b1);
        chk("rst_ready0", wr_ready0, 1'b0);
        chk("rst_ready1", wr_ready1, 1'b0);
        chk("rst_we", mem_we0, 1'b0);
        wr_valid = 1'b0;

        preload(15'd0, 8'hE0);
        preload(15'd1, 8'h1C);
        preload(15'd200, 8'h3C);
        preload(15'd30000, 8'h00);
        rst = 1'b1;
        tick();
        settle();
        chk("idle_addr", mem_addr0, 15'd0);
        chk("idle_wdata", mem_wdata0, 8'h00);
        chk("idle_we", mem_we0, 1'b0);
        tick();

        // Line y=0: fetch alignment, de delay and first frame_start
        for (int i = 0; i < 12; i++) begin
            if (i < 8) pix(1'b1, i, 0); else pix(1'b0, 0, 0);
            settle();
            chk("line0_rgb", rgb0, exp_rgb_a[i]);
            chk("line0_de", de0, (i >= 2) && (i < 10));
            chk("line0_fs", fs0, i == 1);
            chk("line0_fs_tf", fs1, i == 1);
            if (i == 0) chk("line0_addr_x0", mem_addr0, 15'd0);
            if (i == 4) chk("line0_addr_x4", mem_addr0, 15'd1);
            tick();
        end

        // Display slot beats a pending host write
        pix(1'b1, 8, 4);
        wr_valid = 1'b1; wr_addr = 15'd500; wr_data = 8'h5A;
        settle();
        chk("slot_ready", wr_ready0, 1'b0);
        chk("slot_addr", mem_addr0, 15'd202);
        chk("slot_we", mem_we0, 1'b0);
        tick();
        pix(1'b1, 9, 4);
        settle();
        chk("free_ready", wr_ready0, 1'b1);
        chk("free_we", mem_we0, 1'b1);
        chk("free_addr", mem_addr0, 15'd500);
        chk("free_wdata", mem_wdata0, 8'h5A);
        chk("free_ready_tf", wr_ready1, 1'b0);
        tick();
        wr_valid = 1'b0;
        pix(1'b0, 0, 0);
        settle();
        chk("ram_500", ram0[500], 8'h5A);

        // Out-of-range write is accepted then dropped
        wr_valid = 1'b1; wr_addr = 15'd30000; wr_data = 8'hFF;
        settle();
        chk("oor_ready", wr_ready0, 1'b1);
        chk("oor_we", mem_we0, 1'b0);
        tick();
        wr_valid = 1'b0;
        settle();
        chk("oor_drop", wr_drop0, 1'b1);
        tick();
        chk("oor_drop_end", wr_drop0, 1'b0);
        chk("oor_ram", ram0[30000], 8'h00);

        // Last valid address is written, not dropped
        wr_valid = 1'b1; wr_addr = 15'd29999; wr_data = 8'hA5;
        settle();
        chk("edge_we", mem_we0, 1'b1);
        chk("edge_addr", mem_addr0, 15'd29999);
        tick();
        wr_valid = 1'b0;
        settle();
        chk("edge_drop", wr_drop0, 1'b0);
        chk("edge_ram", ram0[29999], 8'hA5);
        tick();

        // Tear-free: write held until the v_sync falling edge moves the FSM to VBLANK
        wr_valid = 1'b1; wr_addr = 15'd1234; wr_data = 8'h77;
        settle();
        chk("tf_hold0", wr_ready1, 1'b0);
        tick();
        chk("tf_hold1", wr_ready1, 1'b0);
        v_sync_in = 1'b0;
        settle();
        chk("tf_hold_edge", wr_ready1, 1'b0);
        tick();
        chk("tf_ready", wr_ready1, 1'b1);
        chk("tf_we", mem_we1, 1'b1);
        chk("tf_addr", mem_addr1, 15'd1234);
        chk("tf_vso_d1", vso1, 1'b1);
        tick();
        wr_valid = 1'b0;
        settle();
        chk("tf_ram", ram1[1234], 8'h77);
        chk("tf_vso_d2", vso1, 1'b0);
        tick();
        v_sync_in = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) pix(1'b1, i, 0); else pix(1'b0, 0, 0);
            settle();
            chk("tf_fs", fs1, i == 1);
            chk("tf_fs0", fs0, i == 1);
            tick();
        end

        // Reset asserted mid-line
        h_sync_in = 1'b0; v_sync_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix(1'b1, i, 4);
            if (i == 2) begin
                settle();
                chk("pre_rst_rgb", rgb0, 8'h3C);
                chk("pre_rst_hs", hso0, 1'b0);
                chk("pre_rst_vs", vso0, 1'b0);
            end
            tick();
        end
        pix(1'b1, 3, 4);
        wr_valid = 1'b1; wr_addr = 15'd10; wr_data = 8'h01;
        settle();
        chk("pre_rst_ready", wr_ready0, 1'b1);
        rst = 1'b0;
        settle();
        chk("mid_rst_rgb", rgb0, 8'h00);
        chk("mid_rst_hs", hso0, 1'b1);
        chk("mid_rst_vs", vso0, 1'b1);
        chk("mid_rst_ready", wr_ready0, 1'b0);
        chk("mid_rst_we", mem_we0, 1'b0);
        chk("mid_rst_de", de0, 1'b0);
        wr_valid = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        pix(1'b0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) pix(1'b1, i, 4); else pix(1'b0, 0, 0);
            settle();
            chk("post_rst_rgb", rgb0, exp_rgb_b[i]);
            chk("post_rst_fs", fs0, i == 1);
            chk("post_rst_de", de0, (i >= 2) && (i < 6));
            tick();
        end

        // Continuous host traffic across a line: slots keep priority, other cycles write
        for (int i = 0; i < 32; i++) begin
            rnd_data[i] = 8'($urandom_range(0, 255));
            pix(1'b1, i, 8);
            wr_valid = 1'b1; wr_addr = 15'(1000 + i); wr_data = rnd_data[i];
            settle();
            if (i % 4 == 0) begin
                chk("traffic_slot_we", mem_we0, 1'b0);
                chk("traffic_slot_addr", mem_addr0, 15'(400 + i / 4));
            end else begin
                chk("traffic_wr_we", mem_we0, 1'b1);
                chk("traffic_wr_addr", mem_addr0, 15'(1000 + i));
            end
            tick();
        end
        wr_valid = 1'b0;
        pix(1'b0, 0, 0);
        tick();
        for (int i = 1; i < 32; i++) begin
            if (i % 4 != 0) chk("traffic_ram", ram0[1000 + i], rnd_data[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port, synchronous-read 8-bit pixel RAM between the VGA scan-out and a host write port. The framebuffer is 200x150 RGB332, and each stored pixel is scaled 4x4 onto the 800x600 raster. The block sits between the 800x600 sync generator and the DAC pins. Display fetches always win the RAM. Host writes use every free cycle, or vertical blanking only when tear-free mode is set. Sync and data-enable are delayed so they stay aligned with the fetched pixel.

Parameters:
FB_W, 200, framebuffer width in pixels (raster x divided by 4)
FB_H, 150, framebuffer height in lines (raster y divided by 4)
ADDR_W, 15, RAM address width
TEAR_FREE, 0, 1 = host writes granted only in VBLANK state

Ports:
clock  in  1  pixel clock
rst  in  1  reset, asynchronous, active-low
active_zone  in  1  visible-area flag from sync generator
h_sync_in  in  1  horizontal sync, active-low
v_sync_in  in  1  vertical sync, active-low
x_pos  in  11  raster x; valid only when active_zone=1 (high-Z otherwise)
y_pos  in  11  raster y; valid only when active_zone=1 (high-Z otherwise)
wr_valid  in  1  host write request
wr_ready  out  1  host write grant
wr_addr  in  ADDR_W  host pixel address (y*FB_W+x)
wr_data  in  8  host RGB332 data
wr_drop  out  1  one-cycle pulse: accepted write was out of range and discarded
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid one cycle after address
rgb_out  out  8  pixel to DAC
h_sync_out  out  1  h_sync_in delayed 2 cycles
v_sync_out  out  1  v_sync_in delayed 2 cycles
de_out  out  1  active_zone delayed 2 cycles
frame_start  out  1  one-cycle pulse at the first visible pixel of each frame

Behaviour:
- Reset (rst=0, asynchronous):
  - rgb_out=0, de_out=0, frame_start=0, wr_drop=0.
  - h_sync_out=1, v_sync_out=1.
  - Delay pipeline cleared: sync stages 1, de stages 0.
  - FSM enters VBLANK.
  - wr_ready=0 and mem_we=0 while rst=0.
- Display slot: disp_slot = active_zone & (x_pos[1:0]==0).
  - mem_addr = (y_pos>>2)*FB_W + (x_pos>>2), mem_we=0.
  - Multiply by FB_W=200 uses shifts: (y<<7)+(y<<6)+(y<<3).
  - x_pos/y_pos are never used when active_zone=0; high-Z inputs must not propagate.
- Read pipeline:
  - Cycle T is the display slot; mem_rdata is valid in T+1.
  - rgb_out loads mem_rdata at the end of T+1 and holds for 4 cycles.
- Delay alignment:
  - h_sync, v_sync and active_zone pass through 2-stage registers.
  - Result: raster pixel x appears on rgb_out exactly 2 cycles after x_pos=x.
  - rgb_out is forced to 0 whenever the delayed de stage is 0.
- Write grant:
  - wr_ready = rst & ~disp_slot & (~TEAR_FREE | state==VBLANK). It is combinational and depends on no valid signal.
  - A write is accepted when wr_valid & wr_ready.
  - If wr_addr < FB_W*FB_H: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle.
  - Otherwise mem_we=0 and wr_drop pulses high the next cycle.
  - If there is no display slot and no accepted write: mem_addr=0, mem_we=0, mem_wdata=0.
- FSM (2 states):
  - ACTIVE -> VBLANK on a falling edge of v_sync_in (registered compare with previous value).
  - VBLANK -> ACTIVE on the first cycle with active_zone=1. frame_start pulses in that same cycle, registered, so it is visible the next cycle.
  - After reset, the first frame_start occurs at the first visible pixel.
- Simultaneous events: the display slot always beats a host request. The host must hold wr_valid, wr_addr and wr_data until wr_ready.
- Reset mid-frame: the pipeline and FSM restart cleanly. Display resumes at the next active pixel with correct 2-cycle alignment.

Test Plan:
- Preload RAM[0]=0xE0, RAM[1]=0x1C; run line y=0 -> rgb_out=0xE0 for 4 cycles starting 2 cycles after x_pos=0, then 0x1C for x=4..7; de_out matches the 2-cycle delay.
- With active_zone=1, x_pos=8, y_pos=4, a write is pending -> wr_ready=0 and mem_addr=202. At x_pos=9 -> wr_ready=1, mem_we=1, mem_addr=wr_addr.
- Write wr_addr=30000, wr_data=0xFF -> handshake completes, mem_we=0, wr_drop=1 for one cycle, RAM unchanged.
- TEAR_FREE=1, wr_valid held from mid-frame -> wr_ready stays 0 until the v_sync_in falling edge, then the write completes in VBLANK; frame_start pulses once at the next frame's first pixel.
- Assert rst=0 mid-line -> rgb_out=0, h_sync_out=v_sync_out=1, wr_ready=0 immediately. After release, the next frame displays correctly and frame_start pulses once.
- Full frame with random host traffic vs reference model -> every RAM write lands at the correct address; no display fetch is ever delayed or overwritten.
